// File: rtl/rca_digit_serial.sv
// rca_digit_serial: digit-serial ripple-carry adder.
// Adds two WIDTH-bit operands DIGIT bits per clock over NDIG = WIDTH/DIGIT
// ADD cycles. A one-cycle done pulse follows. s/cout/ovf are registered and
// only update on the completion edge.
//
// Optional feature: define RCA_DIGIT_SERIAL_SUB_EN to add the 'sub' port.
// With sub=1 at start, the block computes A-B (cin ignored), and cout=1
// means no borrow.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   start  - operation request, sampled only in IDLE
//   a, b   - operands, captured on the accepted start edge
//   cin    - carry-in, captured on the accepted start edge
//   sub    - subtract select (RCA_DIGIT_SERIAL_SUB_EN only)
//   busy   - high whenever the FSM is not IDLE
//   done   - one-cycle completion pulse
//   s      - registered sum (mod 2^WIDTH)
//   cout   - registered carry out of bit WIDTH-1
//   ovf    - registered two's-complement overflow
module rca_digit_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_DIGIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dsum;
    logic              c_top;
    logic [WIDTH-1:0]  sum_next;
    logic              last;

    always_comb begin
        a_dig    = a_r[idx*DIGIT +: DIGIT];
        b_dig    = b_r[idx*DIGIT +: DIGIT];
        dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        // Carry into the digit's top bit recovered from sum = a ^ b ^ cin;
        // on the last digit this is the carry into bit WIDTH-1.
        c_top    = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
        // Completed sum including the digit being added this cycle.
        sum_next = sum_r;
        sum_next[idx*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        last     = (idx == IDXW'(NDIG - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        idx   <= '0;
                        sum_r <= '0;
`ifdef RCA_DIGIT_SERIAL_SUB_EN
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_r   <= b;
                        carry <= cin;
`endif
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum_r <= sum_next;
                    carry <= dsum[DIGIT];
                    if (last) begin
                        idx   <= '0;
                        s     <= sum_next;
                        cout  <= dsum[DIGIT];
                        ovf   <= c_top ^ dsum[DIGIT];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rca_digit_serial.md
RCA_DIGIT_SERIAL -- requirements
Module: rca_digit_serial

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and sum width in bits.
REQ-002 Parameter DIGIT, default 4, SHALL set the bits added per clock; WIDTH SHALL be an integer multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  SHALL be operand A, captured on the accepted start edge.
REQ-007 b  input  WIDTH  SHALL be operand B, captured on the accepted start edge.
REQ-008 cin  input  1  SHALL be the carry-in, captured on the accepted start edge.
REQ-009 sub  input  1  SHALL select subtract, captured on the accepted start edge; present only when SUB_EN is defined.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 s  output  WIDTH  SHALL be the registered sum.
REQ-013 cout  output  1  SHALL be the registered carry out of bit WIDTH-1.
REQ-014 ovf  output  1  SHALL be the registered two's-complement overflow flag.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 In IDLE with start=1, the rising edge SHALL capture a, b and cin into internal registers, clear the digit index to 0, set the carry register to cin, and enter ADD.
REQ-017 In ADD, each edge SHALL add digit i of A, digit i and the carry register (a DIGIT-bit ripple add), store the DIGIT-bit result in slot i of the internal sum register, update the carry register, and increment i.
REQ-018 The edge that processes digit NDIG-1 SHALL load s, cout and ovf from the completed sum and enter DONE.
REQ-019 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-021 Latency: with start accepted at edge E, done SHALL be high during the cycle following edge E+NDIG.
REQ-022 s, cout and ovf SHALL change only at the completion edge and hold their values until the next completion; partial sums SHALL never appear on s.
REQ-023 start SHALL be ignored in ADD and DONE, and a/b/cin changes during an operation SHALL have no effect on it.
REQ-024 Back-to-back operation: start held high continuously SHALL be accepted again on the first edge spent in IDLE after DONE, giving a throughput of one result per NDIG+2 cycles.
REQ-025 When DIGIT=WIDTH, the block SHALL operate correctly with a single ADD cycle.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH, with the carry reported only through cout.

Reset
REQ-027 Asserting reset SHALL, asynchronously, force the state to IDLE and set busy=0, done=0, s=0, cout=0 and ovf=0, and clear the digit index and all internal registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start normally.

Configuration
REQ-029 Macro RCA_DIGIT_SERIAL_SUB_EN: when defined, the port sub SHALL exist, and sub=1 captured at start SHALL invert the captured B and force the initial carry to 1 (cin ignored), computing A-B; cout=1 SHALL then mean no borrow.
REQ-030 When RCA_DIGIT_SERIAL_SUB_EN is undefined, the port sub SHALL be absent and the block SHALL only add.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 a=FFFF, b=0001, cin=0, start at edge E -> done high in the cycle after E+4, s=0000, cout=1, ovf=0, busy high from E through E+5.
REQ-032 a=7FFF, b=0001, cin=0 -> s=8000, cout=0, ovf=1; a=1234, b=4321, cin=1 -> s=5556, cout=0, ovf=0.
REQ-033 Pulse start with a=0001, then while busy pulse start with a=FFFF and change b -> exactly one done pulse, with the result of the first operation.
REQ-034 Assert reset two cycles after start -> outputs 0 immediately, no done pulse; then a=0003, b=0004 -> s=0007.
REQ-035 With SUB_EN: sub=1, a=0005, b=0007 -> s=FFFE, cout=0, ovf=0; sub=1, a=8000, b=0001 -> s=7FFF, cout=1, ovf=1.
REQ-036 WIDTH=8, DIGIT=8, a=FF, b=FF, cin=1 -> s=FF, cout=1, done high in the cycle after E+1.
